// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART transmit-side arbitration blocks.
package uart_pkg;

  localparam int PAYLOAD_BITS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_HOLDOFF = 2'd2,
    ST_DRAIN   = 2'd3
  } arb_state_e;

  // Index width that never collapses to zero bits for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int burst_w(input int mb);
    return (mb > 0) ? $clog2(mb + 1) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the uart_tx handshake, bundled for the arbiter.
// master = requesters/transmitter side, slave = arbiter side.
interface uart_tx_arbiter_if #(
  parameter int N_REQ        = 4,
  parameter int PAYLOAD_BITS = uart_pkg::PAYLOAD_BITS_DEF
);
  import uart_pkg::*;

  localparam int IW = idx_w(N_REQ);

  logic [N_REQ-1:0]              req_valid;
  logic [N_REQ*PAYLOAD_BITS-1:0] req_data;
  logic [N_REQ-1:0]              req_last;
  logic [N_REQ-1:0]              req_break;
  logic [N_REQ-1:0]              req_ready;
  logic                          grant_active;
  logic [IW-1:0]                 grant_id;
  logic                          uart_tx_en;
  logic [PAYLOAD_BITS-1:0]       uart_tx_data;
  logic                          uart_tx_break;
  logic                          uart_tx_busy;

  modport master (
    output req_valid, req_data, req_last, req_break, uart_tx_busy,
    input  req_ready, grant_active, grant_id, uart_tx_en, uart_tx_data, uart_tx_break
  );

  modport slave (
    input  req_valid, req_data, req_last, req_break, uart_tx_busy,
    output req_ready, grant_active, grant_id, uart_tx_en, uart_tx_data, uart_tx_break
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from ptr+1, wrapping.
// Zero latency; no state, the caller owns the pointer.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [idx_w(N)-1:0] ptr,
  output logic [N-1:0]        grant,
  output logic [idx_w(N)-1:0] idx,
  output logic                any
);

  localparam int IW = idx_w(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             start;
  int             off;

  // Rotate so the highest-priority slot lands at bit 0, then take the lowest set bit.
  always_comb begin
    start = (int'(ptr) + 1) % N;
    dbl   = {req, req};
    rot   = N'(dbl >> start);
    off   = 0;
    any   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = i;
        any = 1'b1;
      end
    end
    idx   = IW'((start + off) % N);
    grant = '0;
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one uart_tx; 1-cycle arbitration, byte issued the cycle after req_ready.
// Requesters are held off (req_ready low) until the transmitter is idle and they hold the grant.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int PAYLOAD_BITS   = PAYLOAD_BITS_DEF,
  parameter int HOLDOFF_CYCLES = 2,
  parameter int MAX_BURST      = 0
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = idx_w(N_REQ);
  localparam int BW = burst_w(MAX_BURST);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_ISSUE   = ST_ISSUE;
  localparam logic [1:0] S_HOLDOFF = ST_HOLDOFF;
  localparam logic [1:0] S_DRAIN   = ST_DRAIN;

  logic [1:0]              state;
  logic [IW-1:0]           ptr;
  logic [IW-1:0]           gid;
  logic [N_REQ-1:0]        gnt_oh;
  logic                    gact;
  logic [2:0]              hold_cnt;
  logic [BW-1:0]           burst;
  logic                    last_r;
  logic                    tx_en;
  logic                    tx_brk;
  logic [PAYLOAD_BITS-1:0] tx_data;

  logic [N_REQ-1:0]        rr_grant;
  logic [IW-1:0]           rr_idx;
  logic                    rr_any;
  logic [N_REQ-1:0]        ready;
  logic                    accept;
  logic [PAYLOAD_BITS-1:0] cur_data;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (rr_grant),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  // The one-hot grant mask keeps req_ready a simple AND with the valids.
  assign ready  = (state == S_ISSUE && !bus.uart_tx_busy) ? (gnt_oh & bus.req_valid) : '0;
  assign accept = |ready;

  always_comb begin
    cur_data = bus.req_data[int'(gid)*PAYLOAD_BITS +: PAYLOAD_BITS];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= IW'(N_REQ - 1);
      gid      <= '0;
      gnt_oh   <= '0;
      gact     <= 1'b0;
      hold_cnt <= '0;
      burst    <= '0;
      last_r   <= 1'b0;
      tx_en    <= 1'b0;
      tx_brk   <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_en  <= 1'b0;
      tx_brk <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rr_any) begin
            gid    <= rr_idx;
            gnt_oh <= rr_grant;
            gact   <= 1'b1;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (accept) begin
            tx_en    <= 1'b1;
            tx_data  <= cur_data;
            tx_brk   <= bus.req_break[gid];
            last_r   <= bus.req_last[gid];
            burst    <= burst + 1'b1;
            hold_cnt <= 3'd1;
            state    <= S_HOLDOFF;
          end
        end
        S_HOLDOFF: begin
          // The pulse cycle counts as the first guard cycle; busy may not have risen yet.
          if (hold_cnt == 3'(HOLDOFF_CYCLES)) state <= S_DRAIN;
          else hold_cnt <= hold_cnt + 3'd1;
        end
        S_DRAIN: begin
          if (!bus.uart_tx_busy) begin
            if (last_r || (MAX_BURST != 0 && burst == BW'(MAX_BURST))) begin
              ptr   <= gid;
              burst <= '0;
              gact  <= 1'b0;
              state <= S_IDLE;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready     = ready;
  assign bus.grant_active  = gact;
  assign bus.grant_id      = gid;
  assign bus.uart_tx_en    = tx_en;
  assign bus.uart_tx_data  = tx_data;
  assign bus.uart_tx_break = tx_brk;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Two arbiters (unlimited burst and MAX_BURST=2) driven by queued requesters and a busy model;
// transmitted byte order is checked against a packet-level round-robin reference.
module tb_uart_tx_arbiter;

  typedef struct packed {logic [7:0] d; logic last; logic brk;} ent_t;
  typedef struct packed {logic [1:0] id; logic [7:0] d; logic brk;} pulse_t;

  localparam int BUSY_LEN = 10;
  localparam int MIN_GAP  = 2 + BUSY_LEN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(4), .PAYLOAD_BITS(8)) bus0 ();
  uart_tx_arbiter_if #(.N_REQ(4), .PAYLOAD_BITS(8)) bus1 ();

  uart_tx_arbiter #(.N_REQ(4), .PAYLOAD_BITS(8), .HOLDOFF_CYCLES(2), .MAX_BURST(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  uart_tx_arbiter #(.N_REQ(4), .PAYLOAD_BITS(8), .HOLDOFF_CYCLES(2), .MAX_BURST(2))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [3:0]  v[2], l[2], b[2], mask[2], rdy[2];
  logic [31:0] d[2];
  logic [1:0]  busy, ga, en, txb;
  logic [1:0]  gid[2];
  logic [7:0]  txd[2];
  int          bcnt[2];

  assign bus0.req_valid = v[0]; assign bus0.req_data = d[0];
  assign bus0.req_last  = l[0]; assign bus0.req_break = b[0];
  assign bus0.uart_tx_busy = busy[0];
  assign bus1.req_valid = v[1]; assign bus1.req_data = d[1];
  assign bus1.req_last  = l[1]; assign bus1.req_break = b[1];
  assign bus1.uart_tx_busy = busy[1];
  assign rdy[0] = bus0.req_ready; assign ga[0] = bus0.grant_active; assign gid[0] = bus0.grant_id;
  assign en[0] = bus0.uart_tx_en; assign txd[0] = bus0.uart_tx_data; assign txb[0] = bus0.uart_tx_break;
  assign rdy[1] = bus1.req_ready; assign ga[1] = bus1.grant_active; assign gid[1] = bus1.grant_id;
  assign en[1] = bus1.uart_tx_en; assign txd[1] = bus1.uart_tx_data; assign txb[1] = bus1.uart_tx_break;
  assign busy[0] = (bcnt[0] != 0) && (bcnt[0] <= BUSY_LEN);
  assign busy[1] = (bcnt[1] != 0) && (bcnt[1] <= BUSY_LEN);

  ent_t   q[2][4][$];
  pulse_t obs[2][$];
  int     mptr[2];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     last_en[2] = '{-1, -1};
  logic   prev_en[2] = '{1'b0, 1'b0};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Requesters present their queue head; transmitter goes busy one cycle after uart_tx_en.
  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (rst) bcnt[c] <= 0;
      else if (en[c]) bcnt[c] <= BUSY_LEN + 1;
      else if (bcnt[c] != 0) bcnt[c] <= bcnt[c] - 1;
      for (int i = 0; i < 4; i++) begin
        if (!rst && rdy[c][i] && q[c][i].size() != 0) void'(q[c][i].pop_front());
        if (q[c][i].size() != 0) begin
          v[c][i]        <= mask[c][i];
          d[c][i*8 +: 8] <= q[c][i][0].d;
          l[c][i]        <= q[c][i][0].last;
          b[c][i]        <= q[c][i][0].brk;
        end else begin
          v[c][i] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        prev_en[c] = 1'b0;
        last_en[c] = -1;
      end else begin
        if (rdy[c] != 0) chk("ready_onehot", {ga[c], rdy[c]}, {1'b1, 4'b0001 << gid[c]});
        if (prev_en[c]) begin
          chk("en_one_cycle", en[c], 1'b0);
          chk("break_cleared", txb[c], 1'b0);
        end
        if (en[c]) begin
          if (last_en[c] >= 0) chk("pulse_gap", (cyc - last_en[c]) >= MIN_GAP, 1'b1);
          obs[c].push_back('{id: gid[c], d: txd[c], brk: txb[c]});
          last_en[c] = cyc;
        end
        prev_en[c] = en[c];
      end
    end
  end

  task automatic push(input int c, input int r, input logic [7:0] dat, input logic lst, input logic brk);
    q[c][r].push_back('{d: dat, last: lst, brk: brk});
  endtask

  // Reference: whole packets (or MAX_BURST slices) in round-robin order from the pointer.
  task automatic model(input int c, output pulse_t exp[$]);
    ent_t m[4][$];
    ent_t e;
    int   r, n;
    int   mb = (c == 1) ? 2 : 0;
    for (int i = 0; i < 4; i++) m[i] = q[c][i];
    exp = {};
    while (1) begin
      r = -1;
      for (int k = 1; k <= 4; k++)
        if (r < 0 && m[(mptr[c] + k) % 4].size() != 0) r = (mptr[c] + k) % 4;
      if (r < 0) break;
      n = 0;
      do begin
        e = m[r].pop_front();
        exp.push_back('{id: 2'(r), d: e.d, brk: e.brk});
        n++;
      end while (!e.last && m[r].size() != 0 && !(mb != 0 && n == mb));
      mptr[c] = r;
    end
  endtask

  function automatic bit q_empty(input int c);
    return q[c][0].size() == 0 && q[c][1].size() == 0 && q[c][2].size() == 0 && q[c][3].size() == 0;
  endfunction

  task automatic wait_idle(input int c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(q_empty(c) && !ga[c]) && n < 4000);
    chk("done_in_time", n < 4000, 1'b1);
  endtask

  task automatic compare(input int c, input pulse_t exp[$], input string tag);
    chk({tag, "_count"}, obs[c].size(), exp.size());
    for (int i = 0; i < exp.size() && i < obs[c].size(); i++)
      chk(tag, 32'(obs[c][i]), 32'(exp[i]));
    obs[c] = {};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mptr[0] = 3;
    mptr[1] = 3;
    obs[0] = {};
    obs[1] = {};
  endtask

  initial begin
    pulse_t e0[$];
    pulse_t e1[$];
    int     n;
    int     cnt3;
    mask[0] = 4'hF;
    mask[1] = 4'hF;
    mptr[0] = 3;
    mptr[1] = 3;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      chk("rst_grant_active", ga[c], 1'b0);
      chk("rst_grant_id", gid[c], 2'd0);
      chk("rst_tx_en", en[c], 1'b0);
      chk("rst_tx_data", txd[c], 8'h00);
      chk("rst_tx_break", txb[c], 1'b0);
      chk("rst_ready", rdy[c], 4'h0);
    end
    rst = 1'b0;

    // Single requester, three-byte packet.
    push(0, 0, 8'h41, 1'b0, 1'b0); push(0, 0, 8'h42, 1'b0, 1'b0); push(0, 0, 8'h43, 1'b1, 1'b0);
    model(0, e0);
    wait_idle(0);
    compare(0, e0, "single_pkt");
    chk("single_released", ga[0], 1'b0);

    // Req0 and req2 contend twice; the second round must rotate.
    do_reset();
    push(0, 0, 8'h01, 1'b0, 1'b0); push(0, 0, 8'h02, 1'b1, 1'b0);
    push(0, 2, 8'h21, 1'b0, 1'b0); push(0, 2, 8'h22, 1'b1, 1'b0);
    model(0, e0);
    wait_idle(0);
    compare(0, e0, "contend_r1");
    push(0, 0, 8'h03, 1'b0, 1'b0); push(0, 0, 8'h04, 1'b1, 1'b0);
    push(0, 2, 8'h23, 1'b0, 1'b0); push(0, 2, 8'h24, 1'b1, 1'b0);
    model(0, e0);
    wait_idle(0);
    compare(0, e0, "contend_r2");

    // Req1 stalls mid-packet while req3 waits: grant must stay locked on 1.
    do_reset();
    for (int i = 0; i < 4; i++) push(0, 1, 8'h10 + 8'(i), i == 3, 1'b0);
    push(0, 3, 8'h30, 1'b0, 1'b0); push(0, 3, 8'h31, 1'b1, 1'b0);
    model(0, e0);
    n = 0;
    while (obs[0].size() < 2 && n < 200) begin @(negedge clk); n++; end
    chk("stall_reached", n < 200, 1'b1);
    mask[0][1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      repeat (10) @(negedge clk);
      chk("stall_grant_id", gid[0], 2'd1);
    end
    chk("stall_grant_active", ga[0], 1'b1);
    cnt3 = 0;
    foreach (obs[0][i]) if (obs[0][i].id == 2'd3) cnt3++;
    chk("stall_no_req3", cnt3, 0);
    mask[0][1] = 1'b1;
    wait_idle(0);
    compare(0, e0, "stall_order");

    // Break flag travels with its byte only.
    push(0, 2, 8'h55, 1'b0, 1'b0); push(0, 2, 8'hAA, 1'b1, 1'b1);
    model(0, e0);
    wait_idle(0);
    compare(0, e0, "break_byte");

    // Forced re-arbitration every two bytes.
    do_reset();
    for (int i = 0; i < 5; i++) push(1, 0, 8'hB0 + 8'(i), i == 4, 1'b0);
    for (int i = 0; i < 3; i++) push(1, 1, 8'hC0 + 8'(i), i == 2, 1'b0);
    model(1, e1);
    wait_idle(1);
    compare(1, e1, "burst2");

    // Random packet mixes on both arbiters.
    for (int round = 0; round < 3; round++) begin
      for (int c = 0; c < 2; c++)
        for (int r = 0; r < 4; r++)
          for (int p = $urandom_range(0, 2); p > 0; p--) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++)
              push(c, r, 8'($urandom), i == n - 1, $urandom_range(0, 7) == 0);
          end
      model(0, e0);
      model(1, e1);
      wait_idle(0);
      wait_idle(1);
      compare(0, e0, "rand_ch0");
      compare(1, e1, "rand_ch1");
    end

    // Reset while draining: outputs clear at once, then req0 is granted first.
    do_reset();
    push(0, 0, 8'h60, 1'b0, 1'b0); push(0, 0, 8'h61, 1'b0, 1'b0); push(0, 0, 8'h62, 1'b1, 1'b0);
    push(0, 3, 8'h70, 1'b1, 1'b0);
    n = 0;
    while (obs[0].size() < 1 && n < 200) begin @(negedge clk); n++; end
    chk("drain_reached", n < 200, 1'b1);
    repeat (3) @(negedge clk);
    chk("drain_pre_active", ga[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_tx_en", en[0], 1'b0);
    chk("midrst_ready", rdy[0], 4'h0);
    chk("midrst_grant_active", ga[0], 1'b0);
    chk("midrst_tx_data", txd[0], 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mptr[0] = 3;
    mptr[1] = 3;
    obs[0] = {};
    obs[1] = {};
    model(0, e0);
    wait_idle(0);
    chk("post_rst_first_id", (obs[0].size() != 0) ? 32'(obs[0][0].id) : 32'hFFFF, 0);
    compare(0, e0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares a single uart_tx transmitter between N_REQ byte-stream requesters (status reporter, echo path, debug dump, ...), with round-robin arbitration at packet granularity. It sequences the transmitter handshake: one uart_tx_en pulse per byte, a guard window for the transmitter's delayed busy rise, then a wait for busy to fall. It sits between the top-level message sources and the uart_tx instance, replacing ad-hoc shift-buffer sequencing in the top level.

Parameters:
N_REQ, 4, number of requesters (2..8)
PAYLOAD_BITS, 8, byte width, matches uart_tx
HOLDOFF_CYCLES, 2, cycles after uart_tx_en during which uart_tx_busy is ignored (1..7)
MAX_BURST, 0, bytes per grant before forced re-arbitration; 0 = unlimited (whole packet)

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, asynchronous, active-high
req_valid  in  N_REQ  requester i has a byte
req_data  in  N_REQ*PAYLOAD_BITS  byte of requester i at slice [i*PAYLOAD_BITS +: PAYLOAD_BITS]
req_last  in  N_REQ  byte is the last of its packet
req_break  in  N_REQ  send this byte with uart_tx_break set
req_ready  out  N_REQ  byte of requester i accepted this cycle (combinational)
grant_active  out  1  a requester currently holds the transmitter
grant_id  out  $clog2(N_REQ)  current/last granted requester
uart_tx_en  out  1  one-cycle start pulse to uart_tx (registered)
uart_tx_data  out  PAYLOAD_BITS  byte to uart_tx (registered, held until next issue)
uart_tx_break  out  1  break flag to uart_tx (registered, valid with uart_tx_en)
uart_tx_busy  in  1  transmitter busy

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; rr pointer = N_REQ-1, so requester 0 has first priority; burst counter 0.
- FSM: IDLE, ISSUE, HOLDOFF, DRAIN.
- IDLE: if any req_valid, pick the first valid index searching from ptr+1 with wrap-around. Register grant_id, set grant_active=1, go to ISSUE. Arbitration costs 1 cycle.
- ISSUE: if req_valid[grant_id] and !uart_tx_busy, then:
  - req_ready[grant_id]=1 this cycle.
  - Next cycle: uart_tx_en=1 for exactly one cycle, uart_tx_data=req_data slice, uart_tx_break=req_break bit.
  - Burst counter increments; go to HOLDOFF.
  - If req_valid[grant_id]=0, stay in ISSUE with the grant held (packet lock); no other requester is served.
- HOLDOFF: count HOLDOFF_CYCLES cycles from the uart_tx_en cycle, ignoring busy, then go to DRAIN.
- DRAIN: wait for uart_tx_busy=0. Then:
  - If the accepted byte had req_last, or MAX_BURST != 0 and burst count == MAX_BURST: ptr=grant_id, burst=0, grant_active=0, go to IDLE.
  - Otherwise go to ISSUE.
- Bytes and packets from one requester are never reordered or interleaved with another's unless forced by MAX_BURST. A forced release resumes the same packet at the next grant.
- At most one req_ready bit is high in any cycle; it is never high outside ISSUE.
- uart_tx_break is cleared the cycle after the pulse.
- Simultaneous new requests during a grant are ignored until IDLE. A requester dropping valid while ungranted is harmless.
- Reset mid-byte: outputs clear immediately. Any byte in flight in uart_tx is abandoned, with no replay. Requesters see no req_ready for it.
- N_REQ=1: degenerate, no arbitration stall beyond the 1 IDLE cycle.

Decomposition:
- Package uart_pkg: PAYLOAD_BITS default, the state enum type, and an index-width helper constant/function.
- One natural sub-module: rr_arbiter (N-bit request vector plus pointer -> one-hot grant and index, combinational, with a priority-rotate implementation). This sub-module is reusable for the RX fan-out later.

Test Plan:
- Single requester, 3-byte packet 0x41,0x42,0x43 (last on 0x43), busy model of 10 cycles with 1-cycle rise delay -> three uart_tx_en pulses, each >= HOLDOFF+busy apart, data in order, grant_active drops after 0x43.
- Req0 and req2 both valid from reset, each with a 2-byte packet -> req0's packet fully sent first, then req2's. Next contention between 0 and 2 -> req2 does not win again; order rotates.
- Req1 drops valid mid-packet for 50 cycles while req3 is valid -> no req3 bytes are sent until req1's last byte; grant_id stays 1 throughout.
- MAX_BURST=2, req0 has a 5-byte packet and req1 is valid -> byte order is 0,0,1..,0,0,..,0 with rotation at every 2-byte boundary.
- req_break=1 on byte 0xAA -> uart_tx_break=1 only in the uart_tx_en cycle, 0 afterwards.
- Assert rst during DRAIN -> uart_tx_en, req_ready and grant_active are 0 in the same cycle. After release, the first grant goes to requester 0.
